spi_bus_scheduler: RTL and testbench
====================================

SPI_BUS_SCHEDULER -- requirements
Module: spi_bus_scheduler

Interface
REQ-001 SHALL have parameter SAMPLE_DIV, default 1000: clk cycles between ADC conversion requests (legal range 16..65535).
REQ-002 SHALL have parameter TIMEOUT, default 255: maximum clk cycles a client may hold the bus before being aborted.
REQ-003 SHALL have port clk, input, 1: the single clock; all logic is on its rising edge.
REQ-004 SHALL have port reset_n, input, 1: reset, asynchronous and active-low.
REQ-005 SHALL have port gain_in, input, 8: requested preamp gain word.
REQ-006 SHALL have port gain_wr, input, 1: single-cycle pulse that requests a preamp gain update.
REQ-007 SHALL have port amp_start, output, 1: single-cycle start pulse to the preamp SPI engine.
REQ-008 SHALL have port amp_done, input, 1: pulse from the preamp engine marking transfer end.
REQ-009 SHALL have ports amp_sck, amp_mosi and amp_cs_n, all inputs, 1 each: preamp engine SPI signals.
REQ-010 SHALL have port gain_out, output, 8: gain word presented to the preamp engine.
REQ-011 SHALL have port adc_start, output, 1: single-cycle start pulse to the ADC engine.
REQ-012 SHALL have port adc_done, input, 1: pulse from the ADC engine marking conversion end.
REQ-013 SHALL have ports adc_sck and adc_conv, inputs, 1 each: ADC engine clock and conversion strobe.
REQ-014 SHALL have port adc_sample, input, 16: ADC result, valid while adc_done is high.
REQ-015 SHALL have ports spi_sck and spi_mosi, outputs, 1 each: shared SPI bus.
REQ-016 SHALL have ports amp_cs_n_o (output, 1) and ad_conv_o (output, 1): device selects.
REQ-017 SHALL have ports sample_out (output, 16) and sample_valid (output, 1): latched sample and its one-cycle strobe.
REQ-018 SHALL have ports busy (output, 1), overrun (output, 1) and timeout_err (output, 1): status; overrun and timeout_err are sticky.

Function
REQ-019 FSM SHALL have states AMP_START, AMP_WAIT, IDLE, ADC_START and ADC_WAIT; it enters AMP_START on reset release so the preamp is configured first.
REQ-020 AMP_START SHALL load gain_out from the gain shadow, pulse amp_start for one cycle, clear amp_pending, and go to AMP_WAIT.
REQ-021 In AMP_WAIT, amp_done SHALL cause a transition to IDLE on the next cycle.
REQ-022 In IDLE, amp_pending SHALL win over adc_pending (go to AMP_START); otherwise adc_pending goes to ADC_START; otherwise the FSM stays in IDLE.
REQ-023 ADC_START SHALL pulse adc_start for one cycle, clear adc_pending, and go to ADC_WAIT.
REQ-024 In ADC_WAIT, adc_done SHALL latch adc_sample into sample_out, pulse sample_valid one cycle later, and return to IDLE.
REQ-025 gain_wr SHALL latch gain_in into the shadow and set amp_pending in any state; gain_out SHALL change only in AMP_START.
REQ-026 A 16-bit sample timer SHALL start counting after the first amp_done and count 0..SAMPLE_DIV-1, wrapping to 0; on each wrap it sets adc_pending.
REQ-027 A wrap while adc_pending is already set, or while the FSM is in ADC_START or ADC_WAIT, SHALL set overrun; requests are not queued twice.
REQ-028 A wait counter SHALL clear on entry to AMP_WAIT or ADC_WAIT; on reaching TIMEOUT with no done, the FSM goes to IDLE and sets timeout_err.
REQ-029 After a timeout, the aborted request is not retried.
REQ-030 Bus mux outputs SHALL be registered, one cycle of latency.
REQ-031 Owner amp (AMP_START/AMP_WAIT): spi_sck=amp_sck, spi_mosi=amp_mosi, amp_cs_n_o=amp_cs_n, ad_conv_o=0.
REQ-032 Owner adc (ADC_START/ADC_WAIT): spi_sck=adc_sck, spi_mosi=0, amp_cs_n_o=1, ad_conv_o=adc_conv.
REQ-033 No owner: spi_sck=0, spi_mosi=0, amp_cs_n_o=1, ad_conv_o=0; never both devices selected.
REQ-034 busy SHALL be 1 in every state except IDLE.
REQ-035 A done pulse arriving in a state other than its matching WAIT state SHALL be ignored.

Reset
REQ-036 reset_n low SHALL immediately force the FSM to AMP_START.
REQ-037 reset_n low SHALL immediately set gain shadow and gain_out=8'h00, sample_out=16'h0000, and the timer and wait counter to 0.
REQ-038 reset_n low SHALL immediately clear amp_pending, adc_pending, overrun and timeout_err.
REQ-039 reset_n low SHALL immediately set all pulses=0, spi_sck=0, spi_mosi=0, amp_cs_n_o=1, ad_conv_o=0 and busy=1.
REQ-040 Reset asserted mid-transfer SHALL deselect both devices within the reset assertion, with no clock edge needed.

Verification
REQ-041 Release reset, with amp_done returned 40 cycles after amp_start -> one amp_start, gain_out=00, busy falls, adc_start appears SAMPLE_DIV cycles after amp_done.
REQ-042 ADC engine returns adc_done with adc_sample=16'h2F4A -> sample_out=2F4A with one sample_valid pulse, adc_start repeats every SAMPLE_DIV cycles.
REQ-043 gain_wr with gain_in=8'h11 on the same cycle as a timer wrap -> AMP_START first, gain_out=11, then ADC_START; overrun stays 0.
REQ-044 Hold adc_done low -> FSM returns to IDLE after TIMEOUT cycles, timeout_err=1; the next wrap gives a new adc_start.
REQ-045 SAMPLE_DIV=16 with a 30-cycle ADC transfer -> overrun=1, never two adc_start pulses without an adc_done or timeout between them, amp_cs_n_o and ad_conv_o never both active.
REQ-046 Assert reset_n low during ADC_WAIT -> outputs reach reset values asynchronously, and preamp configuration is redone after release.

Source files
------------

// File: rtl/spi_bus_scheduler.sv
// spi_bus_scheduler: shares one SPI bus between a preamp gain engine and a periodic ADC engine.
// The preamp is always configured first after reset, and the ADC is sampled on a free-running timer.
module spi_bus_scheduler #(
  parameter int SAMPLE_DIV = 1000,
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [7:0]  gain_in,
  input  logic        gain_wr,
  output logic        amp_start,
  input  logic        amp_done,
  input  logic        amp_sck,
  input  logic        amp_mosi,
  input  logic        amp_cs_n,
  output logic [7:0]  gain_out,
  output logic        adc_start,
  input  logic        adc_done,
  input  logic        adc_sck,
  input  logic        adc_conv,
  input  logic [15:0] adc_sample,
  output logic        spi_sck,
  output logic        spi_mosi,
  output logic        amp_cs_n_o,
  output logic        ad_conv_o,
  output logic [15:0] sample_out,
  output logic        sample_valid,
  output logic        busy,
  output logic        overrun,
  output logic        timeout_err
);
  localparam int WW = $clog2(TIMEOUT + 1);
  typedef enum logic [2:0] {AMP_START, AMP_WAIT, IDLE, ADC_START, ADC_WAIT} state_t;
  state_t state, state_nx;
  logic [7:0] gain_sh;
  logic amp_pending, adc_pending, timer_on;
  logic [15:0] timer;
  logic [WW-1:0] wait_cnt;
  logic wrap, waiting, expired, done_now, amp_own, adc_own;
  assign wrap = timer_on && timer == 16'(SAMPLE_DIV - 1);
  assign waiting = state == AMP_WAIT || state == ADC_WAIT;
  assign expired = wait_cnt == WW'(TIMEOUT);
  assign done_now = state == AMP_WAIT ? amp_done : adc_done;
  assign amp_own = state == AMP_START || state == AMP_WAIT;
  assign adc_own = state == ADC_START || state == ADC_WAIT;
  assign busy = state != IDLE;
  always_comb begin
    state_nx = state;
    case (state)
      AMP_START: state_nx = AMP_WAIT;
      AMP_WAIT:  state_nx = (amp_done || expired) ? IDLE : AMP_WAIT;
      IDLE:      state_nx = amp_pending ? AMP_START : adc_pending ? ADC_START : IDLE;
      ADC_START: state_nx = ADC_WAIT;
      ADC_WAIT:  state_nx = (adc_done || expired) ? IDLE : ADC_WAIT;
      default:   state_nx = AMP_START;
    endcase
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= AMP_START;
      gain_sh <= 8'h00;
      gain_out <= 8'h00;
      amp_pending <= 1'b0;
      adc_pending <= 1'b0;
      timer_on <= 1'b0;
      timer <= 16'h0000;
      wait_cnt <= '0;
      overrun <= 1'b0;
      timeout_err <= 1'b0;
      amp_start <= 1'b0;
      adc_start <= 1'b0;
      sample_out <= 16'h0000;
      sample_valid <= 1'b0;
    end else begin
      state <= state_nx;
      gain_sh <= gain_wr ? gain_in : gain_sh;
      gain_out <= state == AMP_START ? gain_sh : gain_out;
      // a write landing in AMP_START must not be lost, so set beats clear
      amp_pending <= gain_wr ? 1'b1 : state == AMP_START ? 1'b0 : amp_pending;
      adc_pending <= (wrap && !adc_own) ? 1'b1 : state == ADC_START ? 1'b0 : adc_pending;
      timer_on <= timer_on | (state == AMP_WAIT && amp_done);
      timer <= (!timer_on || wrap) ? 16'h0000 : timer + 16'd1;
      wait_cnt <= waiting ? wait_cnt + 1'b1 : '0;
      overrun <= overrun | (wrap && (adc_pending || adc_own));
      timeout_err <= timeout_err | (waiting && expired && !done_now);
      amp_start <= state == AMP_START;
      adc_start <= state == ADC_START;
      sample_out <= (state == ADC_WAIT && adc_done) ? adc_sample : sample_out;
      sample_valid <= state == ADC_WAIT && adc_done;
    end
  end
  // bus mux is registered; async reset leaves both devices deselected
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      spi_sck <= 1'b0;
      spi_mosi <= 1'b0;
      amp_cs_n_o <= 1'b1;
      ad_conv_o <= 1'b0;
    end else begin
      spi_sck <= amp_own ? amp_sck : adc_own & adc_sck;
      spi_mosi <= amp_own & amp_mosi;
      amp_cs_n_o <= amp_own ? amp_cs_n : 1'b1;
      ad_conv_o <= adc_own & adc_conv;
    end
  end
endmodule

// File: tb/tb_spi_bus_scheduler.sv
// tb_spi_bus_scheduler: random preamp/ADC engine models with a gain and sample scoreboard.
module tb_spi_bus_scheduler;
  localparam int SD = 16;
  localparam int TO = 60;
  logic clk = 0, reset_n = 1;
  logic [7:0] gain_in = 0;
  logic gain_wr = 0, amp_done = 0, amp_sck = 0, amp_mosi = 0, amp_cs_n = 1;
  logic adc_done = 0, adc_sck = 0, adc_conv = 0;
  logic [15:0] adc_sample = 0;
  logic amp_start, adc_start, spi_sck, spi_mosi, amp_cs_n_o, ad_conv_o;
  logic sample_valid, busy, overrun, timeout_err;
  logic [7:0] gain_out;
  logic [15:0] sample_out;
  int errs = 0, checks = 0;
  logic [7:0] gq[$];
  logic [15:0] sq[$];
  int gidx, amp_cnt = 0, cyc = 0, amp_left = 0, adc_left = 0;
  int amp_lo = 1, amp_hi = 3, adc_lo = 1, adc_hi = 4;
  bit amp_bsy = 0, adc_bsy = 0, adc_hang = 0, saw_adc = 0, saw_amp = 0, saw_tmo = 0, force_s = 0;
  logic [15:0] forced = 0;

  spi_bus_scheduler #(.SAMPLE_DIV(SD), .TIMEOUT(TO)) dut (
    .clk(clk), .reset_n(reset_n), .gain_in(gain_in), .gain_wr(gain_wr),
    .amp_start(amp_start), .amp_done(amp_done), .amp_sck(amp_sck), .amp_mosi(amp_mosi),
    .amp_cs_n(amp_cs_n), .gain_out(gain_out), .adc_start(adc_start), .adc_done(adc_done),
    .adc_sck(adc_sck), .adc_conv(adc_conv), .adc_sample(adc_sample), .spi_sck(spi_sck),
    .spi_mosi(spi_mosi), .amp_cs_n_o(amp_cs_n_o), .ad_conv_o(ad_conv_o), .sample_out(sample_out),
    .sample_valid(sample_valid), .busy(busy), .overrun(overrun), .timeout_err(timeout_err));

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // scoreboard monitor: each amp_start must carry a pending gain write, each strobe the next sample
  always @(posedge clk) begin
    #1;
    if (reset_n && amp_start) begin
      amp_cnt++;
      gidx = -1;
      for (int i = 0; i < gq.size(); i++) if (gidx < 0 && gq[i] === gain_out) gidx = i;
      checks++;
      if (gidx < 0) begin
        errs++;
        $display("FAIL gain_out: got %0h expected a pending gain write", gain_out);
      end else repeat (gidx + 1) void'(gq.pop_front());
    end
    if (reset_n && sample_valid) begin
      if (sq.size() == 0) begin
        checks++; errs++;
        $display("FAIL sample_valid: got strobe expected none");
      end else check("sample_out", sample_out, sq.pop_front());
    end
  end

  task automatic step();
    bit new_amp, new_adc;
    @(negedge clk);
    cyc++;
    gain_wr = 0; amp_done = 0; adc_done = 0;
    saw_adc = adc_start; saw_amp = amp_start; saw_tmo = 0;
    new_amp = 0; new_adc = 0;
    if (amp_start) begin
      checks++;
      if (amp_bsy) begin errs++; $display("FAIL amp_overlap: got amp_start expected none while preamp busy"); end
      amp_bsy = 1; new_amp = 1; amp_left = $urandom_range(amp_hi, amp_lo);
    end
    if (adc_start) begin
      checks++;
      if (adc_bsy) begin errs++; $display("FAIL adc_overlap: got adc_start expected none while ADC busy"); end
      adc_bsy = 1; new_adc = 1; adc_left = $urandom_range(adc_hi, adc_lo);
    end
    if (amp_bsy) check("amp_bus", {spi_sck, spi_mosi, amp_cs_n_o, ad_conv_o}, {amp_sck, amp_mosi, amp_cs_n, 1'b0});
    if (adc_bsy) check("adc_bus", {spi_sck, spi_mosi, amp_cs_n_o, ad_conv_o}, {adc_sck, 1'b0, 1'b1, adc_conv});
    checks++;
    if (!amp_cs_n_o && ad_conv_o) begin errs++; $display("FAIL exclusive: got both selected expected at most one"); end
    if (adc_bsy && adc_hang && !busy) begin adc_bsy = 0; saw_tmo = 1; end
    if (amp_bsy && !new_amp) begin
      amp_left--;
      if (amp_left == 0) begin amp_done = 1; amp_bsy = 0; end
    end
    adc_sample = 16'($urandom);
    if (adc_bsy && !new_adc && !adc_hang) begin
      adc_left--;
      if (adc_left == 0) begin
        adc_done = 1; adc_bsy = 0;
        if (force_s) begin adc_sample = forced; force_s = 0; end
        sq.push_back(adc_sample);
      end
    end
    {amp_sck, amp_mosi, amp_cs_n, adc_sck, adc_conv} = 5'($urandom);
  endtask

  task automatic wait_for(input int sel, input int budget, input string nm, output int at);
    int n = 0;
    bit hit;
    do begin
      step(); n++;
      hit = sel == 0 ? saw_adc : sel == 1 ? saw_amp : sel == 2 ? amp_done : sel == 3 ? saw_tmo : adc_done;
    end while (!hit && n < budget);
    at = cyc;
    if (!hit) begin checks++; errs++; $display("FAIL %s: got no event expected one within %0d cycles", nm, budget); end
  endtask

  task automatic check_reset_vals(input string nm);
    check({nm, "_pulses"}, {amp_start, adc_start, sample_valid}, 3'b000);
    check({nm, "_gain"}, gain_out, 8'h00);
    check({nm, "_sample"}, sample_out, 16'h0000);
    check({nm, "_bus"}, {spi_sck, spi_mosi, amp_cs_n_o, ad_conv_o}, 4'b0010);
    check({nm, "_status"}, {busy, overrun, timeout_err}, 3'b100);
  endtask

  initial begin
    int t, td, ta, tp, d;
    #1 reset_n = 0;
    #1 check_reset_vals("rst0");
    gq.push_back(8'h00);
    repeat (3) @(negedge clk);
    reset_n = 1;
    // startup: preamp configured once with a slow engine, then periodic sampling
    amp_lo = 40; amp_hi = 40;
    wait_for(2, 80, "first_amp_done", td);
    amp_lo = 1; amp_hi = 3;
    step(); step();
    check("busy_after_cfg", busy, 1'b0);
    wait_for(0, 40, "first_adc_start", ta);
    d = ta - td;
    checks++;
    if (d < SD || d > SD + 4) begin errs++; $display("FAIL first_adc_delay: got %0d expected %0d..%0d", d, SD, SD + 4); end
    check("amp_start_count", amp_cnt, 1);
    tp = ta;
    wait_for(4, 10, "first_adc_done", t);
    force_s = 1; forced = 16'h2F4A;
    for (int k = 0; k < 6; k++) begin
      wait_for(0, 3 * SD, "adc_period_start", t);
      check("adc_period", t - tp, SD);
      tp = t;
      if (k == 0) begin
        wait_for(4, 10, "adc_done_2f4a", t);
        step();
        check("sample_2f4a", sample_out, 16'h2F4A);
      end
    end
    // gain write sampled on the same edge as the next timer wrap
    repeat (13 - (cyc - tp)) step();
    gain_wr = 1; gain_in = 8'h11; gq.push_back(8'h11);
    ta = -1; td = -1;
    for (int i = 0; i < 40 && (ta < 0 || td < 0); i++) begin
      step();
      if (saw_amp && ta < 0) ta = cyc;
      if (saw_adc && td < 0) td = cyc;
    end
    check("amp_before_adc", ta >= 0 && td > ta, 1);
    check("gain_out_11", gain_out, 8'h11);
    // random gain traffic mixed with sampling, spaced so no overrun can occur
    d = 0;
    for (int i = 0; i < 300; i++) begin
      step();
      if (d > 0) d--;
      else if ($urandom_range(9, 0) == 0) begin
        gain_in = 8'($urandom); gain_wr = 1; gq.push_back(gain_in); d = 24;
      end
    end
    repeat (20) step();
    check("overrun_clean", overrun, 1'b0);
    check("timeout_clean", timeout_err, 1'b0);
    check("gain_q_empty", gq.size(), 0);
    check("sample_q_empty", sq.size(), 0);
    // ADC never answers: abort after TIMEOUT, then sampling resumes
    adc_hang = 1;
    wait_for(0, 2 * SD + 4, "hang_adc_start", ta);
    wait_for(3, TO + 20, "hang_timeout", t);
    d = t - ta;
    checks++;
    if (d < TO || d > TO + 3) begin errs++; $display("FAIL timeout_len: got %0d expected %0d..%0d", d, TO, TO + 3); end
    check("timeout_err", timeout_err, 1'b1);
    adc_hang = 0;
    wait_for(0, 2 * SD + 4, "adc_after_timeout", t);
    repeat (10) step();
    // reset while the ADC owns the bus
    adc_hang = 1;
    wait_for(0, 2 * SD + 4, "pre_reset_adc", t);
    step();
    adc_conv = 1; amp_cs_n = 1;
    @(posedge clk);
    #2 check("ad_conv_pre_reset", {amp_cs_n_o, ad_conv_o}, 2'b11);
    #1 reset_n = 0;
    #1 check_reset_vals("rst_mid");
    amp_bsy = 0; adc_bsy = 0; adc_hang = 0; amp_done = 0; adc_done = 0;
    gq.delete(); sq.delete(); gq.push_back(8'h00);
    repeat (2) @(negedge clk);
    reset_n = 1;
    wait_for(1, 10, "reconfig_amp_start", t);
    check("reconfig_gain", gain_out, 8'h00);
    // slow ADC against a short sample period: overrun, but never double-started
    adc_lo = 30; adc_hi = 30;
    for (int k = 0; k < 4; k++) wait_for(0, 80, "slow_adc_start", t);
    check("overrun_set", overrun, 1'b1);
    check("no_timeout_slow", timeout_err, 1'b0);
    adc_lo = 1; adc_hi = 4;
    for (int i = 0; i < 60 && (adc_bsy || amp_bsy); i++) step();
    repeat (5) step();
    check("final_gain_q", gq.size(), 0);
    check("final_sample_q", sq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
